// File: rtl/memory_stage.sv
// memory_stage
// Fourth pipeline stage. Takes the EX/MEM pipeline register contents, performs
// loads and stores against an internal word-addressed data memory, selects the
// write-back value, and registers the result into the MEM/WB register.
//
// Optional feature macro: MEM_STALL_EN
//   defined   : memory ops take MEM_LAT+1 cycles; stall_MEM holds upstream stages
//   undefined : all ops single-cycle; stall_MEM tied to 0
//
// Parameters:
//   DMEM_DEPTH  data memory depth in 32-bit words (power of two, >= 2)
//   MEM_LAT     memory-op latency in cycles when MEM_STALL_EN is defined (>= 1)
//
// Ports:
//   clk, rst      clock; asynchronous active-high reset
//   RegWr_EX      register-write enable of the incoming instruction
//   MemWr_EX      store request
//   MemRd_EX      load request
//   WBdata_EX     write-back select: 00 ALU, 01 memory, 10 npc3, 11 zero
//   ALUout_EX     ALU result / byte address
//   D             store data
//   npc3          link value
//   rd3           destination register
//   RPzero_EX     squash (annuls memory write, register write and stall)
//   RegWr_MEM     registered write enable to WB
//   rd4           registered destination register
//   WBval_MEM     registered write-back value
//   stall_MEM     combinational; 1 = upstream must hold EX/MEM contents

module memory_stage #(
  parameter int DMEM_DEPTH = 256,
  parameter int MEM_LAT    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RegWr_EX,
  input  logic        MemWr_EX,
  input  logic        MemRd_EX,
  input  logic [1:0]  WBdata_EX,
  input  logic [31:0] ALUout_EX,
  input  logic [31:0] D,
  input  logic [31:0] npc3,
  input  logic [4:0]  rd3,
  input  logic        RPzero_EX,
  output logic        RegWr_MEM,
  output logic [4:0]  rd4,
  output logic [31:0] WBval_MEM,
  output logic        stall_MEM
);

  localparam int AW = $clog2(DMEM_DEPTH);

  generate
    if (MEM_LAT < 1) begin : g_bad_lat
      $error("memory_stage: MEM_LAT must be at least 1");
    end
  endgenerate

  logic [31:0]   dmem [DMEM_DEPTH];
  logic [AW-1:0] word_idx;
  logic          ld;
  logic          st;
  logic          memop;
  logic          op_done;
  logic          mem_we;
  logic [31:0]   rd_data;
  logic [31:0]   wb_val;

  // Byte address to word index; upper bits are dropped so addresses wrap.
  assign word_idx = ALUout_EX[AW+1:2];

  assign ld    = MemRd_EX & ~RPzero_EX;
  assign st    = MemWr_EX & ~RPzero_EX;
  assign memop = ld | st;

  // Read is combinational, so with load+store together the write-back
  // sees the pre-store contents.
  assign rd_data = dmem[word_idx];

  // Gating with rst keeps a store from committing while reset is held.
  assign mem_we = st & op_done & ~rst;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      dmem[word_idx] <= D;
    end
  end

  always_comb begin
    wb_val = 32'h0;
    case (WBdata_EX)
      2'b00:   wb_val = ALUout_EX;
      2'b01:   wb_val = rd_data;
      2'b10:   wb_val = npc3;
      default: wb_val = 32'h0;
    endcase
  end

`ifdef MEM_STALL_EN
  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t        state;
  state_t        state_next;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;
  logic          stall_raw;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // IDLE sees a new memop and starts counting down; WAIT stalls until the
  // counter reaches zero, which is the cycle the op completes.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    stall_raw  = 1'b0;
    case (state)
      S_IDLE: begin
        if (memop) begin
          stall_raw  = 1'b1;
          state_next = S_WAIT;
          cnt_next   = CW'(MEM_LAT - 1);
        end
      end
      S_WAIT: begin
        if (cnt != '0) begin
          stall_raw = 1'b1;
          cnt_next  = cnt - 1'b1;
        end else begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign op_done   = (state == S_WAIT) && (cnt == '0);
  // Reset forces the FSM to IDLE, but an IDLE memop would raise stall
  // combinationally; mask it so stall drops the moment reset asserts.
  assign stall_MEM = stall_raw & ~rst;
`else
  assign op_done   = 1'b1;
  assign stall_MEM = 1'b0;
`endif

  // MEM/WB register; a stalled edge inserts a bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      RegWr_MEM <= 1'b0;
      rd4       <= 5'd0;
      WBval_MEM <= 32'h0;
    end else if (stall_MEM) begin
      RegWr_MEM <= 1'b0;
      rd4       <= 5'd0;
      WBval_MEM <= 32'h0;
    end else begin
      RegWr_MEM <= RegWr_EX & ~RPzero_EX;
      rd4       <= rd3;
      WBval_MEM <= wb_val;
    end
  end

endmodule

// File: tb/tb_memory_stage.sv
// Directed testbench for memory_stage. Runs in both configurations; the
// stall-sequence section is only compiled when MEM_STALL_EN is defined.

module tb_memory_stage;

  logic        clk;
  logic        rst;
  logic        RegWr_EX;
  logic        MemWr_EX;
  logic        MemRd_EX;
  logic [1:0]  WBdata_EX;
  logic [31:0] ALUout_EX;
  logic [31:0] D;
  logic [31:0] npc3;
  logic [4:0]  rd3;
  logic        RPzero_EX;
  logic        RegWr_MEM;
  logic [4:0]  rd4;
  logic [31:0] WBval_MEM;
  logic        stall_MEM;

  int total;
  int bad;

  memory_stage #(
    .DMEM_DEPTH(256),
    .MEM_LAT   (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .RegWr_EX  (RegWr_EX),
    .MemWr_EX  (MemWr_EX),
    .MemRd_EX  (MemRd_EX),
    .WBdata_EX (WBdata_EX),
    .ALUout_EX (ALUout_EX),
    .D         (D),
    .npc3      (npc3),
    .rd3       (rd3),
    .RPzero_EX (RPzero_EX),
    .RegWr_MEM (RegWr_MEM),
    .rd4       (rd4),
    .WBval_MEM (WBval_MEM),
    .stall_MEM (stall_MEM)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Drives one instruction at the falling edge, waits out any stall, then
  // lets the completing rising edge load MEM/WB and samples just after it.
  task automatic applyStimulus(input logic rw, input logic mw, input logic mr,
                               input logic [1:0] sel, input logic [31:0] alu,
                               input logic [31:0] d, input logic [31:0] npc,
                               input logic [4:0] rd, input logic rp);
    int n;
    @(negedge clk);
    RegWr_EX  = rw;
    MemWr_EX  = mw;
    MemRd_EX  = mr;
    WBdata_EX = sel;
    ALUout_EX = alu;
    D         = d;
    npc3      = npc;
    rd3       = rd;
    RPzero_EX = rp;
    #1;
    n = 0;
    while (stall_MEM && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 50) checkOutput("stall_timeout", 32'd1, 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    rst       = 1'b1;
    RegWr_EX  = 1'b0;
    MemWr_EX  = 1'b0;
    MemRd_EX  = 1'b0;
    WBdata_EX = 2'b00;
    ALUout_EX = 32'h0;
    D         = 32'h0;
    npc3      = 32'h0;
    rd3       = 5'd0;
    RPzero_EX = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_regwr", {31'd0, RegWr_MEM}, 32'd0);
    checkOutput("rst_rd4",   {27'd0, rd4},       32'd0);
    checkOutput("rst_wbval", WBval_MEM,          32'h0);
    checkOutput("rst_stall", {31'd0, stall_MEM}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // store then load from the same word with different byte offset
    applyStimulus(1'b0, 1'b1, 1'b0, 2'b00, 32'h10, 32'hDEADBEEF, 32'h0, 5'd0, 1'b0);
    checkOutput("st_regwr", {31'd0, RegWr_MEM}, 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b1, 2'b01, 32'h13, 32'h0, 32'h0, 5'd5, 1'b0);
    checkOutput("ld_regwr", {31'd0, RegWr_MEM}, 32'd1);
    checkOutput("ld_rd4",   {27'd0, rd4},       32'd5);
    checkOutput("ld_wbval", WBval_MEM,          32'hDEADBEEF);

    // address wrap: 0x400 maps to word 0
    applyStimulus(1'b0, 1'b1, 1'b0, 2'b00, 32'h400, 32'h1234, 32'h0, 5'd0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, 2'b01, 32'h0, 32'h0, 32'h0, 5'd2, 1'b0);
    checkOutput("wrap_wbval", WBval_MEM, 32'h1234);

    // squashed store must not write memory nor the register file
    @(negedge clk);
    RegWr_EX  = 1'b1;
    MemWr_EX  = 1'b1;
    MemRd_EX  = 1'b0;
    WBdata_EX = 2'b00;
    ALUout_EX = 32'h10;
    D         = 32'hFFFF_FFFF;
    rd3       = 5'd7;
    RPzero_EX = 1'b1;
    #1;
    checkOutput("sq_stall", {31'd0, stall_MEM}, 32'd0);
    @(posedge clk);
    #1;
    checkOutput("sq_regwr", {31'd0, RegWr_MEM}, 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b1, 2'b01, 32'h10, 32'h0, 32'h0, 5'd4, 1'b0);
    checkOutput("sq_mem", WBval_MEM, 32'hDEADBEEF);

    // write-back mux selections
    applyStimulus(1'b1, 1'b0, 1'b0, 2'b10, 32'h99, 32'h0, 32'h44, 5'd31, 1'b0);
    checkOutput("mux_npc", WBval_MEM, 32'h44);
    checkOutput("mux_rd4", {27'd0, rd4}, 32'd31);
    applyStimulus(1'b1, 1'b0, 1'b0, 2'b11, 32'h99, 32'h0, 32'h44, 5'd9, 1'b0);
    checkOutput("mux_zero", WBval_MEM, 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 2'b00, 32'h7, 32'h0, 32'h44, 5'd3, 1'b0);
    checkOutput("mux_alu", WBval_MEM, 32'h7);

    // load+store together: write-back sees old contents, store still lands
    applyStimulus(1'b0, 1'b1, 1'b0, 2'b00, 32'h20, 32'h1111_1111, 32'h0, 5'd0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, 2'b01, 32'h20, 32'h2222_2222, 32'h0, 5'd8, 1'b0);
    checkOutput("ldst_old", WBval_MEM, 32'h1111_1111);
    applyStimulus(1'b1, 1'b0, 1'b1, 2'b01, 32'h20, 32'h0, 32'h0, 5'd8, 1'b0);
    checkOutput("ldst_new", WBval_MEM, 32'h2222_2222);

`ifdef MEM_STALL_EN
    // held load: stall 1,1,0 then data, then the same load restarts
    @(negedge clk);
    RegWr_EX  = 1'b1;
    MemWr_EX  = 1'b0;
    MemRd_EX  = 1'b1;
    WBdata_EX = 2'b01;
    ALUout_EX = 32'h10;
    rd3       = 5'd6;
    RPzero_EX = 1'b0;
    #1;
    checkOutput("stl_c0", {31'd0, stall_MEM}, 32'd1);
    @(posedge clk); #1;
    checkOutput("stl_c1", {31'd0, stall_MEM}, 32'd1);
    checkOutput("stl_b1", {31'd0, RegWr_MEM}, 32'd0);
    @(posedge clk); #1;
    checkOutput("stl_c2", {31'd0, stall_MEM}, 32'd0);
    checkOutput("stl_b2", {31'd0, RegWr_MEM}, 32'd0);
    @(posedge clk); #1;
    checkOutput("stl_rw", {31'd0, RegWr_MEM}, 32'd1);
    checkOutput("stl_val", WBval_MEM, 32'hDEADBEEF);
    checkOutput("b2b_c0", {31'd0, stall_MEM}, 32'd1);
    @(posedge clk); #1;
    checkOutput("b2b_c1", {31'd0, stall_MEM}, 32'd1);
    checkOutput("b2b_b1", {31'd0, RegWr_MEM}, 32'd0);
    @(posedge clk); #1;
    checkOutput("b2b_c2", {31'd0, stall_MEM}, 32'd0);
    @(posedge clk); #1;
    checkOutput("b2b_rw", {31'd0, RegWr_MEM}, 32'd1);
    checkOutput("b2b_val", WBval_MEM, 32'hDEADBEEF);

    // reset during WAIT drops the pending store
    @(negedge clk);
    RegWr_EX  = 1'b0;
    MemWr_EX  = 1'b1;
    MemRd_EX  = 1'b0;
    WBdata_EX = 2'b00;
    ALUout_EX = 32'h10;
    D         = 32'h0000_0BAD;
    @(posedge clk); #1;
    checkOutput("wrst_pre", {31'd0, stall_MEM}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("wrst_stall", {31'd0, stall_MEM}, 32'd0);
    @(negedge clk);
    MemWr_EX = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b1, 2'b01, 32'h10, 32'h0, 32'h0, 5'd1, 1'b0);
    checkOutput("wrst_mem", WBval_MEM, 32'hDEADBEEF);
`endif

    // asynchronous reset mid-cycle with random inputs
    applyStimulus(1'b1, 1'b0, 1'b0, 2'b00, 32'h7, 32'h0, 32'h0, 5'd3, 1'b0);
    @(negedge clk);
    RegWr_EX  = 1'b1;
    MemWr_EX  = 1'b0;
    MemRd_EX  = 1'($urandom_range(1, 0));
    WBdata_EX = 2'($urandom_range(3, 0));
    ALUout_EX = $urandom;
    D         = $urandom;
    npc3      = $urandom;
    rd3       = 5'($urandom_range(31, 1));
    RPzero_EX = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    checkOutput("arst_regwr", {31'd0, RegWr_MEM}, 32'd0);
    checkOutput("arst_rd4",   {27'd0, rd4},       32'd0);
    checkOutput("arst_wbval", WBval_MEM,          32'h0);
    checkOutput("arst_stall", {31'd0, stall_MEM}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    RegWr_EX = 1'b0;
    MemRd_EX = 1'b0;
    rst      = 1'b0;
    @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/memory_stage.md
# memory_stage

Fourth pipeline stage: consumes the EX/MEM pipeline register contents, performs data-memory loads and stores against an internal word-addressed data memory, and selects the write-back value. Registers the result into the MEM/WB pipeline register for the write-back stage. An optional multi-cycle memory model adds a stall handshake toward the upstream stages.

## Interface

Parameters:
- DMEM_DEPTH, 256: data memory depth in 32-bit words; power of two.
- MEM_LAT, 2: memory-op latency in cycles when MEM_STALL_EN is defined; must be ≥1; ignored otherwise.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; asynchronous, active-high.
- RegWr_EX  in  1  register-write enable of the incoming instruction.
- MemWr_EX  in  1  store request.
- MemRd_EX  in  1  load request.
- WBdata_EX  in  2  write-back source select: 00 ALU, 01 memory, 10 npc3, 11 zero.
- ALUout_EX  in  32  ALU result; byte address for loads/stores.
- D  in  32  store data.
- npc3  in  32  next-PC, used as the link value.
- rd3  in  5  destination register.
- RPzero_EX  in  1  squash: 1 = instruction annulled (no memory write, no register write, no stall).
- RegWr_MEM  out  1  registered write enable to WB.
- rd4  out  5  registered destination register.
- WBval_MEM  out  32  registered write-back value.
- stall_MEM  out  1  combinational; 1 = upstream must hold EX/MEM contents stable.

## Operation

- Word index = ALUout_EX[log2(DMEM_DEPTH)+1:2]; bits [1:0] ignored; higher bits ignored, so out-of-range addresses wrap modulo DMEM_DEPTH.
- Effective op: ld = MemRd_EX & ~RPzero_EX; st = MemWr_EX & ~RPzero_EX; memop = ld | st. MemRd_EX and MemWr_EX both high: store performed; write-back value follows WBdata_EX with read data reflecting pre-store contents.
- Store: memory[index] <= D at the rising edge on which the op completes.
- Load: combinational array read; value used per WBdata_EX.
- Write-back mux: 00 ALUout_EX, 01 read data, 10 npc3, 11 32'h0.
- MEM/WB register on each non-stalled edge: RegWr_MEM <= RegWr_EX & ~RPzero_EX; rd4 <= rd3; WBval_MEM <= mux output.
- Stalled edge: MEM/WB loads a bubble: RegWr_MEM <= 0, rd4 <= 0, WBval_MEM <= 0.
- Memory contents are not reset; verification writes before reading.

## Timing

- Reset (asynchronous): RegWr_MEM=0, rd4=0, WBval_MEM=0, FSM=IDLE, counter=0, so stall_MEM=0 immediately. Reset during a pending store cancels it; memory unchanged.
- Without MEM_STALL_EN: every op completes in its first cycle; stall_MEM tied 0; latency EX/MEM input to MEM/WB output = 1 edge.
- With MEM_STALL_EN, FSM states IDLE and WAIT, down-counter cnt:
  - IDLE & memop: stall_MEM=1; next state WAIT, cnt <= MEM_LAT-1.
  - WAIT & cnt≠0: stall_MEM=1; cnt <= cnt-1.
  - WAIT & cnt=0: stall_MEM=0; op completes (store commits, load result registered); next IDLE.
  - IDLE & ~memop: stall_MEM=0; no state change.
- Memop holds MEM input for MEM_LAT+1 cycles, stall_MEM high for the first MEM_LAT; result reaches MEM/WB MEM_LAT+1 edges after arrival.
- Back-to-back memops: the next op is seen in IDLE on the cycle after completion and restarts the sequence; no idle gap required.
- Squashed instruction (RPzero_EX=1) never enters WAIT.

## Configuration

- MEM_STALL_EN defined: FSM, counter and stall_MEM generation compiled in; memory ops take MEM_LAT+1 cycles.
- MEM_STALL_EN undefined: FSM and counter absent; stall_MEM constant 0; all ops single-cycle.

## Test plan

- Reset: assert rst mid-cycle with random inputs -> all outputs 0 immediately and stall_MEM=0 (both configurations).
- Store/load: store D=32'hDEADBEEF at ALUout_EX=32'h10, then load from 32'h13 with WBdata_EX=01, rd3=5 -> RegWr_MEM=1, rd4=5, WBval_MEM=32'hDEADBEEF.
- Wrap: DMEM_DEPTH=256, store 32'h1234 at 32'h400, load from 32'h0 -> WBval_MEM=32'h1234.
- Squash: store 32'hFFFF_FFFF at 32'h10 with RPzero_EX=1, RegWr_EX=1 -> memory still 32'hDEADBEEF, RegWr_MEM=0, stall_MEM=0.
- Mux: WBdata_EX=10, npc3=32'h44 -> WBval_MEM=32'h44; WBdata_EX=11 -> 0; WBdata_EX=00, ALUout_EX=7 -> 7.
- Stall (MEM_STALL_EN, MEM_LAT=2): load held stable -> stall_MEM=1,1,0 on three cycles; bubbles (RegWr_MEM=0) after edges 1–2; data valid after edge 3; second back-to-back load stalls again 2 cycles; rst during WAIT -> IDLE, pending store dropped.
